// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_A = 2'd1,
    ARB_GNT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux.sv
// Existing single-bit 2:1 mux: sel=0 passes a, sel=1 passes b.
module mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic o1
);

  assign o1 = sel ? b : a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a bank of 2:1 muxes between requesters A and B.
// Grants and the mux select are registered; a side that keeps requesting while
// the other waits is forced off after MAX_HOLD consecutive cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [DATA_W-1:0] o1,
  output logic              o1_valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_b_q, last_b_d;
  logic          gnt_a_q, gnt_b_q, sel_q;

  // Next grant owner, hold counter and last-served side from live requests.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_b_d = last_b_q;

    case (state_q)
      ARB_IDLE: begin
        if (req_a && req_b)
          state_d = last_b_q ? ARB_GNT_A : ARB_GNT_B;
        else if (req_a)
          state_d = ARB_GNT_A;
        else if (req_b)
          state_d = ARB_GNT_B;
      end
      ARB_GNT_A: begin
        if (!req_a)
          state_d = req_b ? ARB_GNT_B : ARB_IDLE;
        else if (req_b && (hold_q == HOLD_LAST))
          state_d = ARB_GNT_B;
      end
      ARB_GNT_B: begin
        if (!req_b)
          state_d = req_a ? ARB_GNT_A : ARB_IDLE;
        else if (req_a && (hold_q == HOLD_LAST))
          state_d = ARB_GNT_A;
      end
      default: state_d = ARB_IDLE;
    endcase

    if ((state_d == ARB_GNT_A) && (state_q != ARB_GNT_A)) begin
      hold_d   = '0;
      last_b_d = 1'b0;
    end else if ((state_d == ARB_GNT_B) && (state_q != ARB_GNT_B)) begin
      hold_d   = '0;
      last_b_d = 1'b1;
    end else if (state_d == ARB_IDLE) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Single state register; grant and select outputs are registered with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      hold_q   <= '0;
      last_b_q <= 1'b1;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      sel_q    <= SEL_A;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_b_q <= last_b_d;
      gnt_a_q  <= (state_d == ARB_GNT_A);
      gnt_b_q  <= (state_d == ARB_GNT_B);
      sel_q    <= (state_d == ARB_GNT_B) ? SEL_B : SEL_A;
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign sel      = sel_q;
  assign o1_valid = gnt_a_q | gnt_b_q;

  // One shared mux per data bit, all steered by the registered select.
  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux u_mux (
      .a  (a[i]),
      .b  (b[i]),
      .sel(sel_q),
      .o1 (o1[i])
    );
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: two builds (MAX_HOLD=4 and MAX_HOLD=1)
// share one stimulus stream and are compared against a cycle-level ownership model.
module tb_mux_rr_arbiter;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst, req_a, req_b;
  logic [DW-1:0] a, b;

  logic gntA0, gntB0, sel0, valid0;
  logic [DW-1:0] o0;
  logic gntA1, gntB1, sel1, valid1;
  logic [0:0] o1x;

  int totalChecks = 0;
  int badChecks   = 0;

  // Model state per build: owner 0=none 1=A 2=B, run = consecutive cycles owned.
  int ownerM [2];
  int runM   [2];
  int lastM  [2];
  int maxHoldM [2] = '{4, 1};

  // Free-running clock.
  always #5 clk = ~clk;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut0 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gntA0), .gnt_b(gntB0), .sel(sel0), .o1(o0), .o1_valid(valid0)
  );

  mux_rr_arbiter #(.DATA_W(1), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a[0:0]), .b(b[0:0]),
    .gnt_a(gntA1), .gnt_b(gntB1), .sel(sel1), .o1(o1x), .o1_valid(valid1)
  );

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one build's model by one clock edge using the sampled inputs.
  task automatic modelStep(input int k);
    int nextOwner, other;
    logic reqMine, reqOther;
    if (rst) begin
      ownerM[k] = 0;
      runM[k]   = 0;
      lastM[k]  = 2;
    end else if (ownerM[k] == 0) begin
      if (req_a && req_b) nextOwner = (lastM[k] == 1) ? 2 : 1;
      else if (req_a)     nextOwner = 1;
      else if (req_b)     nextOwner = 2;
      else                nextOwner = 0;
      ownerM[k] = nextOwner;
      if (nextOwner != 0) begin
        runM[k]  = 1;
        lastM[k] = nextOwner;
      end
    end else begin
      other    = 3 - ownerM[k];
      reqMine  = (ownerM[k] == 1) ? req_a : req_b;
      reqOther = (ownerM[k] == 1) ? req_b : req_a;
      if (!reqMine)                             nextOwner = reqOther ? other : 0;
      else if (reqOther && runM[k] >= maxHoldM[k]) nextOwner = other;
      else                                      nextOwner = ownerM[k];
      if (nextOwner == ownerM[k]) begin
        runM[k]++;
      end else if (nextOwner != 0) begin
        runM[k]  = 1;
        lastM[k] = nextOwner;
      end else begin
        runM[k] = 0;
      end
      ownerM[k] = nextOwner;
    end
  endtask

  // Compare the data path of both builds against the current owner.
  task automatic checkData();
    checkOutput("o1_dut0", 32'(o0), 32'((ownerM[0] == 2) ? b : a));
    checkOutput("o1_dut1", 32'(o1x), 32'((ownerM[1] == 2) ? b[0] : a[0]));
  endtask

  // Compare grants, select, valid, one-hot and data of both builds.
  task automatic checkAll();
    checkOutput("ctl_dut0", {28'd0, gntA0, gntB0, sel0, valid0},
                {28'd0, ownerM[0] == 1, ownerM[0] == 2, ownerM[0] == 2, ownerM[0] != 0});
    checkOutput("ctl_dut1", {28'd0, gntA1, gntB1, sel1, valid1},
                {28'd0, ownerM[1] == 1, ownerM[1] == 2, ownerM[1] == 2, ownerM[1] != 0});
    checkOutput("onehot", {30'd0, gntA0 & gntB0, gntA1 & gntB1}, 32'd0);
    checkData();
  endtask

  // Drive one cycle of inputs, clock it, update the model and check.
  task automatic applyStimulus(input logic r, input logic ra, input logic rb,
                               input logic [DW-1:0] da, input logic [DW-1:0] db);
    rst = r; req_a = ra; req_b = rb; a = da; b = db;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkAll();
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    ownerM = '{0, 0}; runM = '{0, 0}; lastM = '{2, 2};
    #2;

    $display("[TB] reset with both requests high");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 4'hA);
      checkOutput("rst_gnt", {30'd0, gntA0, gntB0}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h5, 4'hA);
    checkOutput("first_tie_a", {31'd0, gntA0}, 32'd1);

    $display("[TB] A alone for 10 cycles");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
      checkOutput("a_only_gnt", {30'd0, gntA0, sel0}, 32'd2);
    end

    $display("[TB] both requesting continuously");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 4'(k), 4'(~k));
      checkOutput("rot4", {31'd0, gntA0}, {31'd0, ((k / 4) % 2) == 0});
      checkOutput("rot1", {31'd0, gntA1}, {31'd0, (k % 2) == 0});
    end

    $display("[TB] handover when A drops");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h3, 4'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 4'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h3, (i % 2 == 0) ? 4'hC : 4'h0);
      checkOutput("handover_b", {30'd0, gntB0, sel0}, 32'd3);
      b = ~b;
      #1;
      checkData();
    end

    $display("[TB] reset during B grant");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h6, 4'h9);
    checkOutput("rst_mid_gnt", {30'd0, gntB0, sel0}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h6, 4'h9);
    checkOutput("post_rst_a", {31'd0, gntA0}, 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0,
                    4'($urandom), 4'($urandom));
      a = 4'($urandom);
      b = 4'($urandom);
      #1;
      checkData();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
